// File: rtl/mul_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_op_sequencer_pkg
// Brief    : Shared state encoding, default parameters and width helpers.
// Revision : 1.0
// ============================================================================
package mul_op_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int C_DEF_WIDTH        = 32;
    localparam int C_DEF_DEPTH        = 4;
    localparam int C_DEF_START_CYCLES = 4;
    localparam int C_DEF_MAX_WAIT     = 1023;

    // One counter serves both the start pulse and the watchdog.
    function automatic int cnt_width(input int start_cycles, input int max_wait);
        int m;
        m = (start_cycles > max_wait) ? start_cycles : max_wait;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_op_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mul_op_fifo
// Brief    : Synchronous operand FIFO holding {mcand, mplier} pairs.
// Revision : 1.0
// ============================================================================
module mul_op_fifo
    import mul_op_sequencer_pkg::*;
#(
    parameter int DATA_W = 2 * C_DEF_WIDTH,
    parameter int DEPTH  = C_DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              w_push;
    logic              w_pop;

    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_op_sequencer
// Brief    : Queues multiply requests and issues them one at a time to a
//            sequential multiply unit, returning results on a valid/ready port.
// Revision : 1.0
// ============================================================================
module mul_op_sequencer
    import mul_op_sequencer_pkg::*;
#(
    parameter int WIDTH        = C_DEF_WIDTH,
    parameter int DEPTH        = C_DEF_DEPTH,
    parameter int START_CYCLES = C_DEF_START_CYCLES,
    parameter int MAX_WAIT     = C_DEF_MAX_WAIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_mcand,
    input  logic [WIDTH-1:0]   in_mplier,
    output logic [WIDTH-1:0]   mul_mcand,
    output logic [WIDTH-1:0]   mul_mplier,
    output logic               mul_start,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_finished,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [WIDTH-1:0]   out_mcand,
    output logic [WIDTH-1:0]   out_mplier,
    output logic               busy,
    output logic               timeout_err
);

    localparam int C_CNT_W      = cnt_width(START_CYCLES, MAX_WAIT);
    localparam int C_FIFO_CNT_W = $clog2(DEPTH) + 1;

    state_t               state_q;
    logic [C_CNT_W-1:0]   cnt_q;
    logic                 finished_q;
    logic                 mul_start_q;
    logic [WIDTH-1:0]     mul_mcand_q;
    logic [WIDTH-1:0]     mul_mplier_q;
    logic                 out_valid_q;
    logic [2*WIDTH-1:0]   out_product_q;
    logic [WIDTH-1:0]     out_mcand_q;
    logic [WIDTH-1:0]     out_mplier_q;
    logic                 timeout_q;

    logic [2*WIDTH-1:0]   w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [C_FIFO_CNT_W-1:0] w_count;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_edge;

    assign w_push = in_valid && !w_full;
    assign w_pop  = (state_q == IDLE) && !w_empty;
    assign w_edge = mul_finished && !finished_q;

    mul_op_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_push),
        .push_data_i ({in_mcand, in_mplier}),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            finished_q    <= 1'b0;
            mul_start_q   <= 1'b0;
            mul_mcand_q   <= '0;
            mul_mplier_q  <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_mcand_q   <= '0;
            out_mplier_q  <= '0;
            timeout_q     <= 1'b0;
        end else begin
            finished_q <= mul_finished;
            case (state_q)
                IDLE: begin
                    if (!w_empty) begin
                        mul_mcand_q  <= w_head[2*WIDTH-1:WIDTH];
                        mul_mplier_q <= w_head[WIDTH-1:0];
                        mul_start_q  <= 1'b1;
                        cnt_q        <= C_CNT_W'(START_CYCLES - 1);
                        state_q      <= START;
                    end
                end
                START: begin
                    if (cnt_q == '0) begin
                        mul_start_q <= 1'b0;
                        state_q     <= WAIT;
                    end else begin
                        cnt_q <= cnt_q - C_CNT_W'(1);
                    end
                end
                WAIT: begin
                    // A finishing edge beats a watchdog expiry in the same cycle.
                    if (w_edge) begin
                        out_product_q <= mul_product;
                        out_mcand_q   <= mul_mcand_q;
                        out_mplier_q  <= mul_mplier_q;
                        out_valid_q   <= 1'b1;
                        state_q       <= DONE;
                    end else if (cnt_q == C_CNT_W'(MAX_WAIT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + C_CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = !w_full;
    assign busy        = (state_q != IDLE) || (w_count != '0);
    assign mul_start   = mul_start_q;
    assign mul_mcand   = mul_mcand_q;
    assign mul_mplier  = mul_mplier_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign out_mcand   = out_mcand_q;
    assign out_mplier  = out_mplier_q;
    assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_op_sequencer
// Brief    : Self-checking bench with a behavioural multiply unit and a
//            queue-based model of request ordering and FIFO occupancy.
// Revision : 1.0
// ============================================================================
module tb_mul_op_sequencer;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int SC = 4;
    localparam int MW = 20;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_mcand = '0;
    logic [W-1:0]   in_mplier = '0;
    logic [W-1:0]   mul_mcand;
    logic [W-1:0]   mul_mplier;
    logic           mul_start;
    logic [2*W-1:0] mul_product = '0;
    logic           mul_finished = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_product;
    logic [W-1:0]   out_mcand;
    logic [W-1:0]   out_mplier;
    logic           busy;
    logic           timeout_err;

    always #5 clk = ~clk;

    mul_op_sequencer #(
        .WIDTH(W), .DEPTH(D), .START_CYCLES(SC), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mcand(in_mcand), .in_mplier(in_mplier),
        .mul_mcand(mul_mcand), .mul_mplier(mul_mplier), .mul_start(mul_start),
        .mul_product(mul_product), .mul_finished(mul_finished),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_mcand(out_mcand), .out_mplier(out_mplier),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Multiply unit model. mode 0: normal, 1: never finishes,
    // 2: finished already high (with a bogus product) until a late low-high.
    int           mode = 0;
    int           lat = 4;
    int           m_cnt = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;

    always @(posedge clk) begin
        if (mul_start) begin
            m_a          <= mul_mcand;
            m_b          <= mul_mplier;
            m_cnt        <= (mode == 1) ? 0 : lat;
            mul_finished <= (mode == 2);
            mul_product  <= (mode == 2) ? 64'hDEAD_BEEF_0BAD_F00D : '0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (mode == 2 && m_cnt == 2) mul_finished <= 1'b0;
            if (m_cnt == 1) begin
                mul_finished <= 1'b1;
                mul_product  <= 64'(m_a) * 64'(m_b);
            end
        end
    end

    int             checks = 0;
    int             failures = 0;
    int             occ = 0;
    bit             acc_pend = 1'b0;
    logic           start_prev = 1'b0;
    logic [2*W-1:0] exp_q[$];

    // Advance to the next negedge and update the occupancy model: a push
    // lands on the edge it was offered for, a pop shows up as a start rising.
    task automatic tick();
        @(negedge clk);
        if (acc_pend) occ++;
        if (mul_start && !start_prev) occ--;
        start_prev = mul_start;
        acc_pend   = 1'b0;
    endtask

    task automatic offer(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, output bit acc);
        in_valid  = v;
        in_mcand  = a;
        in_mplier = b;
        acc = v && in_ready;
        if (acc) begin
            exp_q.push_back({a, b});
            acc_pend = 1'b1;
        end
    endtask

    task automatic apply_reset(input int cycles);
        reset    = 1'b1;
        in_valid = 1'b0;
        acc_pend = 1'b0;
        repeat (cycles) @(negedge clk);
        reset      = 1'b0;
        occ        = 0;
        start_prev = mul_start;
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset(2);
        tick();
        checks++;
        if ({in_ready, out_valid, busy, timeout_err, mul_start} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=%b", {in_ready, out_valid, busy, timeout_err, mul_start}, 5'b10000);
        end
        checks++;
        if ({out_product, out_mcand, out_mplier, mul_mcand, mul_mplier} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {out_product, out_mcand, out_mplier, mul_mcand, mul_mplier});
        end
    endtask

    task automatic test_single();
        bit acc;
        int first_start = -1;
        int starts = 0;
        int ov = 0;
        int t_ov = -1;
        logic [2*W-1:0] e;
        mode = 0; lat = 5; out_ready = 1'b1;
        offer(1'b1, 14, 13, acc);
        checks++;
        if (acc !== 1'b1) begin failures++; $display("FAIL single_accept got=%b want=1", acc); end
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (t == 1) in_valid = 1'b0;
            if (mul_start) begin
                starts++;
                if (first_start < 0) first_start = t;
            end
            if (t_ov >= 0 && t == t_ov + 1) begin
                checks++;
                if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b want=0", busy); end
            end
            if (out_valid) begin
                ov++;
                if (t_ov < 0) begin
                    t_ov = t;
                    e = exp_q.pop_front();
                    checks++;
                    if (out_product !== 64'd182) begin failures++; $display("FAIL single_product got=%0d want=182", out_product); end
                    checks++;
                    if ({out_mcand, out_mplier} !== e) begin failures++; $display("FAIL single_operands got=%h want=%h", {out_mcand, out_mplier}, e); end
                end
            end
        end
        checks++;
        if (first_start != 2) begin failures++; $display("FAIL single_start_latency got=%0d want=2", first_start); end
        checks++;
        if (starts != SC) begin failures++; $display("FAIL single_start_len got=%0d want=%0d", starts, SC); end
        checks++;
        if (ov != 1) begin failures++; $display("FAIL single_out_valid_cycles got=%0d want=1", ov); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   a[16];
        logic [W-1:0]   b[16];
        logic [2*W-1:0] e;
        logic [2*W-1:0] p;
        int nxt = 0;
        int got = 0;
        bit acc;
        for (int i = 0; i < 5; i++) begin a[i] = W'(2 * i + 2); b[i] = W'(2 * i + 3); end
        for (int i = 5; i < 16; i++) begin a[i] = $urandom; b[i] = $urandom; end
        mode = 0;
        for (int t = 0; t < 1500 && got < 16; t++) begin
            tick();
            lat = $urandom_range(1, 8);
            checks++;
            if (in_ready !== (occ < D)) begin failures++; $display("FAIL b2b_in_ready got=%b want=%b occ=%0d", in_ready, (occ < D), occ); end
            out_ready = (t < 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected got=%h want=none", out_product);
                end else begin
                    e = exp_q.pop_front();
                    p = 64'(e[2*W-1:W]) * 64'(e[W-1:0]);
                    if ({out_product, out_mcand, out_mplier} !== {p, e}) begin
                        failures++; $display("FAIL b2b_result got=%h want=%h", {out_product, out_mcand, out_mplier}, {p, e});
                    end
                end
                got++;
            end
            if (nxt < 16) begin
                offer(1'b1, a[nxt], b[nxt], acc);
                if (acc) nxt++;
            end else begin
                in_valid = 1'b0;
            end
        end
        tick();
        checks++;
        if (got != 16 || busy !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0d busy=%b want=16 busy=0", got, busy); end
    endtask

    task automatic test_stall();
        bit acc;
        int t_ov = -1;
        logic [2*W-1:0] e;
        logic [2*W-1:0] p;
        mode = 0; lat = 3; out_ready = 1'b0;
        offer(1'b1, 14, 13, acc);
        for (int t = 1; t <= 60 && t_ov < 0; t++) begin
            tick();
            in_valid = 1'b0;
            if (out_valid) t_ov = t;
        end
        checks++;
        if (t_ov < 0) begin failures++; $display("FAIL stall_first_result got=none want=out_valid"); end
        for (int t = 0; t < 20; t++) begin
            offer(1'b1, $urandom, $urandom, acc);
            tick();
            checks++;
            if ({out_valid, mul_start, out_product} !== {1'b1, 1'b0, 64'd182}) begin
                failures++; $display("FAIL stall_hold got=%h want=%h", {out_valid, mul_start, out_product}, {1'b1, 1'b0, 64'd182});
            end
            checks++;
            if (in_ready !== (occ < D)) begin failures++; $display("FAIL stall_in_ready got=%b want=%b", in_ready, (occ < D)); end
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_full got=%b want=0", in_ready); end
        in_valid = 1'b0;
        for (int t = 0; t < 400 && exp_q.size() > 0; t++) begin
            out_ready = $urandom_range(0, 1);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                p = 64'(e[2*W-1:W]) * 64'(e[W-1:0]);
                checks++;
                if ({out_product, out_mcand, out_mplier} !== {p, e}) begin
                    failures++; $display("FAIL stall_result got=%h want=%h", {out_product, out_mcand, out_mplier}, {p, e});
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL stall_drain left=%0d busy=%b want=0", exp_q.size(), busy); end
    endtask

    task automatic test_level_finished();
        bit acc;
        int got = 0;
        logic [2*W-1:0] e;
        mode = 2; lat = 6; out_ready = 1'b1;
        offer(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
        for (int t = 1; t <= 80 && got == 0; t++) begin
            tick();
            in_valid = 1'b0;
            if (out_valid) begin
                got = 1;
                e = exp_q.pop_front();
                checks++;
                if (out_product !== 64'hFFFF_FFFE_0000_0001) begin
                    failures++; $display("FAIL level_product got=%h want=%h", out_product, 64'hFFFF_FFFE_0000_0001);
                end
                checks++;
                if ({out_mcand, out_mplier} !== e) begin failures++; $display("FAIL level_operands got=%h want=%h", {out_mcand, out_mplier}, e); end
            end
        end
        checks++;
        if (got == 0) begin failures++; $display("FAIL level_no_result got=none want=out_valid"); end
        tick();
        mode = 0;
    endtask

    task automatic test_timeout();
        bit acc;
        int t_last = -1;
        int t_err = -1;
        int got = 0;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        mode = 1; lat = 4; out_ready = 1'b1;
        offer(1'b1, $urandom, $urandom, acc);
        tick();
        a2 = $urandom; b2 = $urandom;
        offer(1'b1, a2, b2, acc);
        for (int t = 2; t <= 150 && got == 0; t++) begin
            tick();
            if (t == 2) in_valid = 1'b0;
            if (mul_start && t_err < 0) t_last = t;
            if (t_last > 0 && !mul_start && mode == 1) mode = 0;
            if (timeout_err && t_err < 0) begin
                t_err = t;
                if (exp_q.size() > 0) exp_q.delete(0);
            end
            if (out_valid) begin
                got = 1;
                checks++;
                if ({out_product, out_mcand, out_mplier} !== {64'(a2) * 64'(b2), a2, b2}) begin
                    failures++; $display("FAIL timeout_next_result got=%h want=%h", {out_product, out_mcand, out_mplier}, {64'(a2) * 64'(b2), a2, b2});
                end
            end
        end
        checks++;
        if (t_err != t_last + MW + 1) begin failures++; $display("FAIL timeout_latency got=%0d want=%0d", t_err, t_last + MW + 1); end
        checks++;
        if (got == 0) begin failures++; $display("FAIL timeout_next_op got=none want=out_valid"); end
        tick();
        checks++;
        if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b want=1", timeout_err); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit acc;
        bit seen = 1'b0;
        int got = 0;
        mode = 0; lat = 15; out_ready = 1'b1;
        offer(1'b1, $urandom, $urandom, acc); tick();
        offer(1'b1, $urandom, $urandom, acc); tick();
        offer(1'b1, $urandom, $urandom, acc); tick();
        in_valid = 1'b0;
        for (int t = 0; t < 30; t++) begin
            if (mul_start) seen = 1'b1;
            if (seen && !mul_start) break;
            tick();
        end
        tick(); tick();
        apply_reset(1);
        checks++;
        if ({in_ready, out_valid, busy, timeout_err, mul_start} !== 5'b10000) begin
            failures++; $display("FAIL midreset_flags got=%b want=%b", {in_ready, out_valid, busy, timeout_err, mul_start}, 5'b10000);
        end
        checks++;
        if ({out_product, out_mcand, out_mplier, mul_mcand, mul_mplier} !== '0) begin
            failures++; $display("FAIL midreset_data got=%h want=0", {out_product, out_mcand, out_mplier, mul_mcand, mul_mplier});
        end
        lat = 5;
        offer(1'b1, 7, 9, acc);
        for (int t = 1; t <= 60 && got == 0; t++) begin
            tick();
            if (t == 1) in_valid = 1'b0;
            if (out_valid) begin
                got = 1;
                checks++;
                if ({out_product, out_mcand, out_mplier} !== {64'd63, 32'd7, 32'd9}) begin
                    failures++; $display("FAIL midreset_result got=%h want=%h", {out_product, out_mcand, out_mplier}, {64'd63, 32'd7, 32'd9});
                end
            end
        end
        checks++;
        if (got == 0) begin failures++; $display("FAIL midreset_no_result got=none want=out_valid"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_level_finished();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=stuck want=finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
